// File: rtl/pio_input_edge_irq_if.sv
// pio_input_edge_irq_if: Avalon-MM slave bus, read latency 1, no wait states.
interface pio_input_edge_irq_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  modport master(output address, write, writedata, input readdata);
  modport slave(input address, write, writedata, output readdata);
endinterface

// File: rtl/pio_input_edge_irq.sv
// pio_input_edge_irq: synchronised, debounced input PIO with sticky edge capture and maskable irq.
module pio_input_edge_irq #(
  parameter int WIDTH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int EDGE_MODE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  pio_input_edge_irq_if.slave  bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);
  localparam int ARM_N = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
  localparam int AW = $clog2(ARM_N + 1);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync, deb, deb_d, det, irqmask, edgecap, w1c;
  logic [AW-1:0] arm_cnt;
  logic armed, wr_mask;
  assign sync = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk or posedge reset)
    if (reset) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb = sync;
  end else begin : g_deb
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [WIDTH-1:0][CW-1:0] cnt;
    logic [WIDTH-1:0] deb_q;
    // any sample that agrees with deb restarts the count, so glitches never land
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        cnt <= '0;
        deb_q <= '0;
      end else
        for (int i = 0; i < WIDTH; i++)
          if (sync[i] == deb_q[i]) cnt[i] <= '0;
          else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            deb_q[i] <= sync[i];
            cnt[i] <= '0;
          end else cnt[i] <= cnt[i] + 1'b1;
    assign deb = deb_q;
  end
  assign armed = arm_cnt == AW'(ARM_N);
  always_ff @(posedge clk or posedge reset)
    if (reset) arm_cnt <= '0;
    else if (!armed) arm_cnt <= arm_cnt + 1'b1;
  always_comb begin
    det = (EDGE_MODE == 0 ? deb & ~deb_d : EDGE_MODE == 1 ? ~deb & deb_d : deb ^ deb_d) & {WIDTH{armed}};
    wr_mask = bus.write && bus.address == 2'd2;
    w1c = (bus.write && bus.address == 2'd3) ? WIDTH'(bus.writedata) : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      deb_d <= '0;
      irqmask <= '0;
      edgecap <= '0;
      irq <= 1'b0;
      bus.readdata <= '0;
    end else begin
      deb_d <= deb;
      if (wr_mask) irqmask <= WIDTH'(bus.writedata);
      edgecap <= det | (edgecap & ~w1c);
      irq <= |(edgecap & irqmask);
      bus.readdata <= bus.address == 2'd0 ? 32'(deb) :
                      bus.address == 2'd2 ? 32'(irqmask) :
                      bus.address == 2'd3 ? 32'(edgecap) : 32'd0;
    end
endmodule

// File: tb/tb_pio_input_edge_irq.sv
// tb_pio_input_edge_irq: three configurations driven with directed and random stimulus against a history-based model.
module tb_pio_input_edge_irq;
  logic clk = 1'b0, reset = 1'b0, run = 1'b0;
  always #5 clk = ~clk;
  localparam int MW [3] = '{4, 4, 32};
  localparam int MSS [3] = '{2, 2, 3};
  localparam int MD [3] = '{0, 8, 0};
  localparam int MEM [3] = '{0, 0, 2};
  logic [1:0] addr [3];
  logic wr [3];
  logic [31:0] wd [3], inp [3];
  wire [31:0] rd [3];
  wire irqo [3];
  int errors = 0, checks = 0;
  pio_input_edge_irq_if bus0(), bus1(), bus2();
  assign bus0.address = addr[0];
  assign bus0.write = wr[0];
  assign bus0.writedata = wd[0];
  assign rd[0] = bus0.readdata;
  assign bus1.address = addr[1];
  assign bus1.write = wr[1];
  assign bus1.writedata = wd[1];
  assign rd[1] = bus1.readdata;
  assign bus2.address = addr[2];
  assign bus2.write = wr[2];
  assign bus2.writedata = wd[2];
  assign rd[2] = bus2.readdata;
  pio_input_edge_irq #(.WIDTH(4)) dut0 (.clk(clk), .reset(reset), .bus(bus0), .in_port(inp[0][3:0]), .irq(irqo[0]));
  pio_input_edge_irq #(.WIDTH(4), .DEBOUNCE_CYCLES(8)) dut1 (.clk(clk), .reset(reset), .bus(bus1), .in_port(inp[1][3:0]), .irq(irqo[1]));
  pio_input_edge_irq #(.WIDTH(32), .SYNC_STAGES(3), .EDGE_MODE(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2), .in_port(inp[2]), .irq(irqo[2]));
  // model state: raw input history (newest first), debounced value, previous deb, registers
  logic [31:0] inh [3][16];
  int hn [3], ecount [3];
  logic [31:0] mdeb [3], mdebd [3], mec [3], mmask [3], exp_rd [3];
  logic exp_irq [3];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] hval(input int k, input int j);
    return j < hn[k] ? inh[k][j] : 32'd0;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      hn[k] = 0;
      ecount[k] = 0;
      mdeb[k] = 0;
      mdebd[k] = 0;
      mec[k] = 0;
      mmask[k] = 0;
      exp_rd[k] = 0;
      exp_irq[k] = 1'b0;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] wm, sn, dn, det, w1c, nec, h;
      bit flip;
      wm = (MW[k] == 32) ? 32'hFFFF_FFFF : (32'd1 << MW[k]) - 32'd1;
      sn = hval(k, MSS[k] - 1);
      dn = (MD[k] == 0) ? sn : mdeb[k];
      det = MEM[k] == 0 ? dn & ~mdebd[k] : MEM[k] == 1 ? ~dn & mdebd[k] : dn ^ mdebd[k];
      if (ecount[k] < MSS[k] + MD[k] + 1) det = 0;
      det &= wm;
      w1c = (wr[k] && addr[k] == 2'd3) ? wd[k] & wm : 32'd0;
      nec = det | (mec[k] & ~w1c);
      exp_irq[k] = |(mec[k] & mmask[k]);
      exp_rd[k] = addr[k] == 2'd0 ? dn : addr[k] == 2'd2 ? mmask[k] : addr[k] == 2'd3 ? mec[k] : 32'd0;
      if (wr[k] && addr[k] == 2'd2) mmask[k] = wd[k] & wm;
      mec[k] = nec;
      mdebd[k] = dn;
      // a bit follows sync once the last D synchronised samples all disagreed with it
      if (MD[k] > 0)
        for (int b = 0; b < MW[k]; b++) begin
          flip = 1'b1;
          for (int j = 0; j < MD[k]; j++) begin
            h = hval(k, MSS[k] - 1 + j);
            if (h[b] == mdeb[k][b]) flip = 1'b0;
          end
          if (flip) mdeb[k][b] = ~mdeb[k][b];
        end
      for (int j = 15; j > 0; j--) inh[k][j] = inh[k][j-1];
      inh[k][0] = inp[k] & wm;
      if (hn[k] < 16) hn[k]++;
      ecount[k]++;
    end
  endtask
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!reset) model_step();
      #2;
    end
  endtask
  task automatic bus_write(input int k, input logic [1:0] a, input logic [31:0] d);
    addr[k] = a;
    wr[k] = 1'b1;
    wd[k] = d;
    cycle();
    wr[k] = 1'b0;
  endtask
  always @(negedge clk)
    if (run)
      for (int k = 0; k < 3; k++) begin
        check($sformatf("rd%0d", k), rd[k], exp_rd[k]);
        check($sformatf("irq%0d", k), {31'd0, irqo[k]}, {31'd0, exp_irq[k]});
      end
  initial begin
    for (int k = 0; k < 3; k++) begin
      addr[k] = 0;
      wr[k] = 0;
      wd[k] = 0;
      inp[k] = 0;
    end
    model_reset();
    inp[0] = 32'hF;
    #1 reset = 1'b1;
    run = 1'b1;
    cycle(3);
    reset = 1'b0;
    cycle(2);
    check("data_before_sync", rd[0], 32'h0);
    cycle();
    check("data_after_reset", rd[0], 32'hF);
    bus_write(0, 2'd2, 32'hF);
    addr[0] = 2'd3;
    cycle(6);
    check("arm_edgecap", rd[0], 32'h0);
    check("arm_irq", {31'd0, irqo[0]}, 32'd0);
    bus_write(0, 2'd2, 32'h4);
    inp[0] = 32'hB;
    cycle(4);
    inp[0] = 32'hF;
    addr[0] = 2'd3;
    cycle(3);
    check("rise_irq_e2", {31'd0, irqo[0]}, 32'd0);
    cycle();
    check("rise_edgecap", rd[0], 32'h4);
    check("rise_irq_e3", {31'd0, irqo[0]}, 32'd1);
    bus_write(0, 2'd3, 32'h4);
    addr[0] = 2'd3;
    cycle();
    check("w1c_edgecap", rd[0], 32'h0);
    check("w1c_irq", {31'd0, irqo[0]}, 32'd0);
    inp[0] = 32'hE;
    cycle(4);
    inp[0] = 32'hF;
    cycle(4);
    inp[0] = 32'hE;
    cycle(4);
    inp[0] = 32'hF;
    cycle(2);
    bus_write(0, 2'd3, 32'h1);
    addr[0] = 2'd3;
    cycle();
    check("set_beats_clear", rd[0], 32'h1);
    bus_write(0, 2'd3, 32'h1);
    inp[1] = 32'h2;
    cycle(5);
    inp[1] = 32'h0;
    cycle(15);
    check("glitch_data", rd[1], 32'h0);
    addr[1] = 2'd3;
    cycle(2);
    check("glitch_cap", rd[1], 32'h0);
    addr[1] = 2'd0;
    inp[1] = 32'h2;
    cycle(10);
    check("deb_not_yet", rd[1], 32'h0);
    cycle();
    check("deb_data", rd[1], 32'h2);
    cycle(9);
    inp[1] = 32'h0;
    addr[1] = 2'd3;
    cycle(2);
    check("deb_cap", rd[1], 32'h2);
    addr[2] = 2'd3;
    inp[2] = 32'h8000_0000;
    cycle(6);
    check("any_rise", rd[2], 32'h8000_0000);
    bus_write(2, 2'd3, 32'h8000_0000);
    cycle();
    check("any_clr", rd[2], 32'h0);
    inp[2] = 32'h0;
    cycle(6);
    check("any_fall", rd[2], 32'h8000_0000);
    check("any_irq", {31'd0, irqo[2]}, 32'd0);
    bus_write(0, 2'd2, 32'hF);
    inp[0] = 32'hC;
    cycle(4);
    inp[0] = 32'hF;
    addr[0] = 2'd3;
    cycle(5);
    check("pre_rst_cap", rd[0], 32'h3);
    check("pre_rst_irq", {31'd0, irqo[0]}, 32'd1);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_rd", rd[0], 32'h0);
    check("async_rst_irq", {31'd0, irqo[0]}, 32'd0);
    cycle();
    reset = 1'b0;
    cycle(2);
    check("post_rst_cap", rd[0], 32'h0);
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 3; k++) begin
        if (MD[k] > 0 ? $urandom_range(11) == 0 : $urandom_range(2) == 0)
          inp[k] = inp[k] ^ (MD[k] > 0 ? 32'd1 << $urandom_range(3) : $urandom);
        addr[k] = 2'($urandom_range(3));
        wr[k] = $urandom_range(3) == 0;
        wd[k] = $urandom;
      end
      if ($urandom_range(699) == 0) begin
        reset = 1'b1;
        model_reset();
        cycle();
        reset = 1'b0;
      end
      cycle();
    end
    for (int k = 0; k < 3; k++) wr[k] = 1'b0;
    cycle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pio_input_edge_irq.md
# pio_input_edge_irq

Parametrised Avalon-MM input PIO slave, successor to the fixed 4-bit switch port. It samples a WIDTH-bit asynchronous input bus through a synchroniser and an optional per-bit debouncer. It latches selected edges into a sticky edge-capture register and raises a maskable level interrupt to the Nios II. It sits on the system interconnect beside the block RAM, with read latency 1 and no wait states.

## Interface
- WIDTH, 4: input bus width, 1..32.
- SYNC_STAGES, 2: synchroniser flops per bit, 2..4.
- DEBOUNCE_CYCLES, 0: consecutive stable cycles required before the debounced value changes; 0 bypasses the debouncer.
- EDGE_MODE, 0: 0 = rising, 1 = falling, 2 = any edge.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select.
- write  in  1  write strobe, single cycle.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt, active-high, registered.

## Operation
- Register map (bits above WIDTH read 0, writes to them ignored):
  - 0 DATA, RO: debounced input value.
  - 1 reserved: reads 0.
  - 2 IRQMASK, RW: per-bit interrupt enable.
  - 3 EDGECAP, RW1C: sticky captured edges.
- Writes to addresses 0 and 1 are ignored.
- readdata updates every clock from address, with no read strobe, matching the existing PIO behaviour:
  - readdata <= zero-extended mux(address) each cycle.
- Synchroniser: SYNC_STAGES-deep flop chain per bit; its output is sync.
- Debouncer, per bit, when DEBOUNCE_CYCLES > 0:
  - Counter of width clog2(DEBOUNCE_CYCLES+1).
  - While sync == deb: counter = 0.
  - While sync != deb: counter increments.
  - On the cycle the counter would reach DEBOUNCE_CYCLES: deb <= sync and counter <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES restarts the count and never reaches deb.
- With DEBOUNCE_CYCLES = 0, deb = sync combinationally.
- Edge detect: deb_d <= deb every cycle. Per EDGE_MODE:
  - rise = deb & ~deb_d
  - fall = ~deb & deb_d
  - any = deb ^ deb_d
- Arming: after reset, an arm counter inhibits edge capture for SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles. This prevents spurious edges from inputs already high at reset release. It stays armed until the next reset.
- EDGECAP bit update: edgecap[i] <= det[i] | (edgecap[i] & ~(write & address==3 & writedata[i])).
  - Set wins over a simultaneous clear.
- irq <= |(edgecap & irqmask), registered.

## Timing
- Reset values: readdata 0, irq 0, irqmask 0, edgecap 0. Sync chain, deb, deb_d, debounce counters and arm counter are all 0 (unarmed).
- Reset is asynchronous; asserting it mid-operation clears everything in the same instant, including pending captures and irq.
- Input latency, with the change stable before edge E0 and D = DEBOUNCE_CYCLES:
  - sync valid after edge E0+SYNC_STAGES-1.
  - deb valid after edge E0+SYNC_STAGES-1+D.
  - edgecap set at the following edge.
  - irq asserts one edge later.
- With defaults: edgecap set at E0+2, irq at E0+3.
- Read: address presented at edge Ea gives readdata valid after Ea, reflecting register state just before Ea.
- Writes take effect at the strobe edge. irq reflects an IRQMASK or EDGECAP write one edge later.
- Multiple bits may capture in the same cycle. A W1C write with writedata = 0 has no effect.

## Test plan
- Reset release with in_port = 4'hF (defaults):
  - DATA reads 0xF after 3 cycles.
  - EDGECAP stays 0 and irq stays 0 (arming).
- Rising edge on bit 2, IRQMASK = 0x4:
  - EDGECAP = 0x4 at E0+2, irq = 1 at E0+3.
  - Write 0x4 to address 3: EDGECAP = 0, irq = 0 one edge later.
- Simultaneous W1C of bit 0 and a new rising edge on bit 0 in the same cycle: EDGECAP[0] stays 1.
- DEBOUNCE_CYCLES = 8:
  - 5-cycle pulse on bit 1: no DATA change, no capture.
  - 20-cycle pulse: DATA[1] = 1 after SYNC_STAGES-1+8 edges, EDGECAP[1] = 1.
- EDGE_MODE = 2, WIDTH = 32:
  - Toggle bit 31 high then low; W1C between the edges.
  - Each transition sets EDGECAP = 0x80000000.
  - IRQMASK = 0 keeps irq = 0 throughout.
- Assert reset while irq = 1 and EDGECAP = 0x3: irq, EDGECAP and readdata are 0 immediately, without waiting for a clock edge.
